// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, widths, FSM states.
package alu_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int OP_W_DEF   = 3;

    localparam logic [2:0] OP_NEG_A = 3'b000;
    localparam logic [2:0] OP_NEG_B = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_XOR   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser of each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       gnt_id,
    output logic       rr_ptr
);

    always_comb begin
        gnt_id = 1'b0;
        unique case (1'b1)
            (valid == 2'b11): gnt_id = rr_ptr;
            (valid == 2'b10): gnt_id = 1'b1;
            default:          gnt_id = 1'b0;
        endcase
        grant = 2'b00;
        if (|valid)
            grant = gnt_id ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (advance)
            rr_ptr <= ~gnt_id;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_GRANT_CNT_EN to add saturating per-requester grant counters.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*OP_W-1:0]   req_op,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_cout,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OP_W-1:0]     alu_sel,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_cout
`ifdef ALU_GRANT_CNT_EN
    ,
    output logic [2*CNT_W-1:0]  grant_cnt
`endif
);

    state_t             state;
    logic               owner;
    logic [1:0]         grant;
    logic               gnt_id;
    logic               rr_ptr;
    logic               accept;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [OP_W-1:0]    sel_op;

    assign accept    = (state == IDLE) && (|req_valid) && !reset;
    assign req_ready = accept ? grant : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   (req_valid),
        .advance (accept),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .rr_ptr  (rr_ptr)
    );

    always_comb begin
        sel_a  = gnt_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        sel_b  = gnt_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        sel_op = gnt_id ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
    end

    // ALU inputs only change on a grant, so the ALU never sees glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_valid <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a   <= sel_a;
                        alu_b   <= sel_b;
                        alu_sel <= sel_op;
                        owner   <= gnt_id;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_cout  <= alu_cout;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (req_ready[0] && req_valid[0] && !(&cnt0))
                cnt0 <= cnt0 + 1'b1;
            if (req_ready[1] && req_valid[1] && !(&cnt1))
                cnt1 <= cnt1 + 1'b1;
        end
    end

    assign grant_cnt = {cnt1, cnt0};
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural 4-bit ALU attached.
module tb_alu_share_ctrl;
    import alu_pkg::*;

`ifdef ALU_GRANT_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [5:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [3:0]  rsp_data;
    logic        rsp_cout;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_out;
    logic        alu_cout;
`ifdef ALU_GRANT_CNT_EN
    logic [2*CW-1:0] grant_cnt;
`endif

    alu_share_ctrl #(.DATA_W(4), .OP_W(3), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout)
`ifdef ALU_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference ALU: {cout, result}; cout is carry for add, borrow for sub.
    function automatic logic [4:0] alu_f(input logic [2:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
        logic [4:0] r;
        r = '0;
        case (op)
            OP_NEG_A: r[3:0] = ~a + 4'd1;
            OP_NEG_B: r[3:0] = ~b + 4'd1;
            OP_ADD:   r = {1'b0, a} + {1'b0, b};
            OP_SUB:   r = {(a < b), 4'(a - b)};
            OP_AND:   r[3:0] = a & b;
            OP_OR:    r[3:0] = a | b;
            OP_MUL:   r[3:0] = 4'(a * b);
            default:  r[3:0] = a ^ b;
        endcase
        return r;
    endfunction

    assign {alu_cout, alu_out} = alu_f(alu_sel, alu_a, alu_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       id;
        logic [3:0] d;
        logic       c;
        int         acc;
    } exp_t;

    exp_t sb[$];
    logic gq[$];
    int   acc_cyc[2];
    int   hs_cyc = 0;
    bit   seen   = 0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rdy_1hot", 32'(req_ready == 2'b11), 0);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    logic [4:0] r;
                    r = alu_f(req_op[i*3 +: 3], req_a[i*4 +: 4], req_b[i*4 +: 4]);
                    sb.push_back('{id: 1'(i), d: r[3:0], c: r[4], acc: cyc});
                    gq.push_back(1'(i));
                    acc_cyc[i] = cyc;
                end
            end
            if (rsp_valid != 2'b00) begin
                chk("rdy_busy", 32'(req_ready), 0);
                if (sb.size() == 0) begin
                    chk("spurious", 32'(rsp_valid), 0);
                end else begin
                    exp_t e;
                    e = sb[0];
                    chk("rsp_vld", 32'(rsp_valid), e.id ? 32'd2 : 32'd1);
                    chk("rsp_data", 32'(rsp_data), 32'(e.d));
                    chk("rsp_cout", 32'(rsp_cout), 32'(e.c));
                    if (!seen) begin
                        chk("latency", 32'(cyc - e.acc), 2);
                        seen = 1;
                    end
                    if (rsp_ready[e.id]) begin
                        void'(sb.pop_front());
                        seen   = 0;
                        hs_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic drive(input int i, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] op);
        req_a[i*4 +: 4]  = a;
        req_b[i*4 +: 4]  = b;
        req_op[i*3 +: 3] = op;
        req_valid[i]     = 1'b1;
    endtask

    task automatic wait_acc(input int i);
        bit ok;
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) ok = 1;
        end
        if (!ok) chk("acc_tmo", 0, 1);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic issue(input int i, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] op);
        drive(i, a, b, op);
        wait_acc(i);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            #1 k++;
        end
        if (sb.size() != 0) chk("drain_tmo", 32'(sb.size()), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({req_ready, rsp_valid, alu_a, alu_b,
                      alu_sel, rsp_data, rsp_cout}), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        sb.delete();
        seen = 0;
        #1 chk_zero("rst_out");
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (rsp_valid == 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (rsp_valid == 2'b00) chk("rsp_tmo", 0, 1);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 2'b11;
        #1 chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        issue(0, 4'b0101, 4'b0011, OP_ADD);   drain();
        issue(0, 4'b1100, 4'b0110, OP_ADD);   drain();
        issue(1, 4'b0101, 4'b0000, OP_NEG_A); drain();
        issue(1, 4'b0101, 4'b0011, OP_MUL);   drain();
        issue(0, 4'b1001, 4'b0100, OP_SUB);   drain();
        issue(1, 4'b0100, 4'b1001, OP_SUB);   drain();
        issue(0, 4'b1010, 4'b0110, OP_AND);   drain();
        issue(1, 4'b1010, 4'b0110, OP_OR);    drain();
        issue(0, 4'b0011, 4'b0111, OP_NEG_B); drain();
        issue(1, 4'b1111, 4'b0101, OP_XOR);   drain();

        // contention from reset: grants must alternate starting at 0
        do_reset();
        gq.delete();
        drive(0, 4'b0111, 4'b0001, OP_ADD);
        drive(1, 4'b0110, 4'b0011, OP_SUB);
        for (int k = 0; k < 60 && gq.size() < 4; k++) begin
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        drain();
        chk("grant_n", 32'(gq.size()), 4);
        for (int k = 0; k < 4; k++)
            chk("grant_ord", 32'(gq[k]), 32'(k % 2));

        // backpressure on requester 0, requester 1 waiting
        do_reset();
        rsp_ready = 2'b10;
        drive(1, 4'b0011, 4'b0011, OP_ADD);
        drive(0, 4'b1000, 4'b1000, OP_ADD);
        wait_acc(0);
        wait_rsp();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rsp_ready = 2'b11;
        wait_acc(1);
        chk("bp_next_gnt", 32'(acc_cyc[1] - hs_cyc), 1);
        drain();

        // reset during EXEC
        drive(0, 4'b0001, 4'b0001, OP_ADD);
        wait_acc(0);
        #1 reset = 1'b1;
        sb.delete();
        seen = 0;
        #1 chk_zero("rst_exec");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        // reset during RESP
        #1 rsp_ready = 2'b00;
        drive(0, 4'b0010, 4'b0010, OP_ADD);
        wait_acc(0);
        wait_rsp();
        @(posedge clk);
        #2 reset = 1'b1;
        sb.delete();
        seen = 0;
        #1 chk_zero("rst_resp");
        @(posedge clk);
        #1 reset = 1'b0;
        rsp_ready = 2'b11;
        repeat (4) @(posedge clk);

        // after reset the pointer favours requester 0 again
        #1 gq.delete();
        drive(0, 4'b0110, 4'b0110, OP_ADD);
        drive(1, 4'b0001, 4'b0010, OP_OR);
        for (int k = 0; k < 20 && gq.size() < 1; k++) begin
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        chk("post_rst_gnt", 32'(gq.size() > 0 ? gq[0] : 1'b1), 0);
        drain();

`ifdef ALU_GRANT_CNT_EN
        do_reset();
        for (int k = 0; k < 5; k++) begin
            issue(0, 4'(k), 4'b0001, OP_ADD);
            drain();
        end
        chk("gcnt0_sat", 32'(grant_cnt[1:0]), 3);
        chk("gcnt1_idle", 32'(grant_cnt[3:2]), 0);
        for (int k = 0; k < 2; k++) begin
            issue(1, 4'(k), 4'b0010, OP_XOR);
            drain();
        end
        chk("gcnt1", 32'(grant_cnt[3:2]), 2);
        chk("gcnt0_hold", 32'(grant_cnt[1:0]), 3);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
